cpu_instruction_fetch: RTL



---
 rtl/cpu_instruction_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cpu_instruction_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack instruction-memory requests, and feeds IF/ID.
// It honours the branch delay slot and has a one-entry skid buffer for stalls. Optional macro FETCH_ADEL_EN adds misaligned-target exception outputs.
module cpu_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_ack,
`ifdef FETCH_ADEL_EN
  output logic        fetch_adel,
  output logic [31:0] fetch_badaddr,
`endif
  output logic [31:0] output_addr,
  output logic [31:0] output_inst,
  output logic        output_valid
);

  // Handshake: a request is outstanding while inst_req=1; it completes on the
  // cycle inst_ack=1, and inst_addr is held constant until that cycle.
  logic        started;
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_inst;
  logic [31:0] pc;
  logic        redirect_pending;
  logic [31:0] redirect_target;
  logic        ack_fire;
  logic        redirect_take;
  logic        slot_captured;
  logic [31:0] target;
  logic        fetch_block;

`ifdef FETCH_ADEL_EN
  logic        apply_direct;
  logic        apply_pending;
  logic [31:0] apply_target;

  assign target        = branch_addr;
  assign fetch_block   = fetch_adel;
  assign apply_direct  = redirect_take & slot_captured;
  assign apply_pending = ack_fire & redirect_pending;
  assign apply_target  = apply_direct ? target : redirect_target;

  // Sticky address-error latch; once set, fetching stops until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_adel    <= 1'b0;
      fetch_badaddr <= 32'h0;
    end else if (!fetch_adel && (apply_direct || apply_pending) && (apply_target[1:0] != 2'b00)) begin
      fetch_adel    <= 1'b1;
      fetch_badaddr <= apply_target;
    end
  end
`else
  assign target      = branch_addr & ~32'h3;
  assign fetch_block = 1'b0;
`endif

  assign inst_req      = started & ~buf_valid & ~fetch_block;
  assign inst_addr     = pc;
  assign ack_fire      = inst_req & inst_ack;
  assign redirect_take = output_valid & ~stall & branch_valid;
  // The delay slot is already safe if it sits in the buffer or completes now.
  assign slot_captured = buf_valid | ack_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started          <= 1'b0;
      pc               <= RESET_PC;
      buf_valid        <= 1'b0;
      buf_addr         <= 32'h0;
      buf_inst         <= 32'h0;
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0;
      output_addr      <= 32'h0;
      output_inst      <= 32'h0;
      output_valid     <= 1'b0;
    end else begin
      started <= 1'b1;

      if (ack_fire) begin
        if (stall) begin
          buf_valid <= 1'b1;
          buf_addr  <= pc;
          buf_inst  <= inst_rdata;
        end
        pc               <= redirect_pending ? redirect_target : pc + 32'd4;
        redirect_pending <= 1'b0;
      end

      if (!stall) begin
        if (buf_valid) begin
          output_addr  <= buf_addr;
          output_inst  <= buf_inst;
          output_valid <= 1'b1;
          buf_valid    <= 1'b0;
        end else if (ack_fire) begin
          output_addr  <= pc;
          output_inst  <= inst_rdata;
          output_valid <= 1'b1;
        end else begin
          output_addr  <= 32'h0;
          output_inst  <= 32'h0;
          output_valid <= 1'b0;
        end
      end

      // Later assignment to pc overrides the pc+4 step above.
      if (redirect_take) begin
        if (slot_captured) begin
          pc <= target;
        end else begin
          redirect_pending <= 1'b1;
          redirect_target  <= target;
        end
      end
    end
  end

endmodule
